// File: rtl/temporizador_notas_if.sv
// Control and status bundle between the note timer and the song-address
// generator, note memory and the audio/video consumers.
interface temporizador_notas_if #(
  parameter int DUR_W = 8
) ();
  logic             iniciar;
  logic             detener;
  logic             pausar;
  logic [DUR_W-1:0] nota_duracion;
  logic             termino;
  logic             empiece;
  logic             cuente;
  logic             nota_activa;
  logic [DUR_W-1:0] tiempo_restante;
  logic             cancion_fin;

  modport master (
    output iniciar, detener, pausar, nota_duracion, termino,
    input  empiece, cuente, nota_activa, tiempo_restante, cancion_fin
  );

  modport slave (
    input  iniciar, detener, pausar, nota_duracion, termino,
    output empiece, cuente, nota_activa, tiempo_restante, cancion_fin
  );
endinterface

// File: rtl/temporizador_notas.sv
// Note timer: starts the song, holds each note for its duration in ticks,
// then pulses the address generator forward until it reports the end.
module temporizador_notas #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100,
  parameter int DUR_W   = 8,
  parameter int MEM_LAT = 1
) (
  input logic           clock,
  input logic           reset,
  temporizador_notas_if.slave bus
);

  localparam int DIV    = CLK_HZ / TICK_HZ;
  localparam int PRE_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int WAIT_W = $clog2(MEM_LAT + 2);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(DIV - 1);
  // CARGA latches once the wait counter reaches MEM_LAT+1; a restart enters
  // at 0 (one extra cycle for the empiece pulse), REVISA enters at 1.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_LAT + 1);

  typedef enum logic [2:0] {
    IDLE, CARGA, TOCA, AVANZA, REVISA, FIN
  } state_t;

  state_t            r_state;
  logic [PRE_W-1:0]  r_pre;
  logic [WAIT_W-1:0] r_wait;
  logic [DUR_W-1:0]  r_tiempo;
  logic              r_empiece;
  logic              r_cuente;
  logic              r_activa;
  logic              r_fin;
  logic              w_tick;

  assign w_tick = (r_pre == PRE_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_pre     <= '0;
      r_wait    <= '0;
      r_tiempo  <= '0;
      r_empiece <= 1'b0;
      r_cuente  <= 1'b0;
      r_activa  <= 1'b0;
      r_fin     <= 1'b0;
    end else begin
      r_empiece <= 1'b0;
      r_cuente  <= 1'b0;
      r_fin     <= 1'b0;
      if (bus.detener) begin
        r_state  <= IDLE;
        r_pre    <= '0;
        r_wait   <= '0;
        r_tiempo <= '0;
        r_activa <= 1'b0;
      end else if (bus.iniciar) begin
        r_state   <= CARGA;
        r_empiece <= 1'b1;
        r_pre     <= '0;
        r_wait    <= '0;
        r_tiempo  <= '0;
        r_activa  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: r_state <= IDLE;
          CARGA: begin
            if (r_wait == WAIT_LAST) begin
              r_tiempo <= bus.nota_duracion;
              if (bus.nota_duracion == '0) begin
                r_state  <= AVANZA;
                r_cuente <= 1'b1;
              end else begin
                r_state  <= TOCA;
                r_activa <= 1'b1;
                r_pre    <= '0;
              end
            end else begin
              r_wait <= r_wait + WAIT_W'(1);
            end
          end
          TOCA: begin
            if (!bus.pausar) begin
              if (w_tick) begin
                r_pre <= '0;
                // Last tick: the count stops at zero rather than wrapping.
                if (r_tiempo <= DUR_W'(1)) begin
                  r_tiempo <= '0;
                  r_activa <= 1'b0;
                  r_state  <= AVANZA;
                  r_cuente <= 1'b1;
                end else begin
                  r_tiempo <= r_tiempo - DUR_W'(1);
                end
              end else begin
                r_pre <= r_pre + PRE_W'(1);
              end
            end
          end
          AVANZA: r_state <= REVISA;
          REVISA: begin
            if (bus.termino) begin
              r_state <= FIN;
              r_fin   <= 1'b1;
            end else begin
              r_state <= CARGA;
              r_wait  <= WAIT_W'(1);
            end
          end
          FIN:     r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.empiece         = r_empiece;
  assign bus.cuente          = r_cuente;
  assign bus.nota_activa     = r_activa;
  assign bus.tiempo_restante = r_tiempo;
  assign bus.cancion_fin     = r_fin;

endmodule

// File: tb/tb_temporizador_notas.sv
// Directed bench for temporizador_notas with a small address-generator and
// note-memory model (DIV=2, MEM_LAT=1).
module tb_temporizador_notas;
  localparam int DUR_W = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  temporizador_notas_if #(.DUR_W(DUR_W)) bus ();

  temporizador_notas #(
    .CLK_HZ(10), .TICK_HZ(5), .DUR_W(DUR_W), .MEM_LAT(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  logic [7:0] mem [0:7];
  int         song_len = 1;
  logic [2:0] addr = 3'd0;

  // Address generator plus synchronous memory: data follows address by one clock,
  // termino is registered on the cuente edge.
  always @(posedge clock) begin
    if (bus.empiece) begin
      addr        <= 3'd0;
      bus.termino <= 1'b0;
    end else if (bus.cuente) begin
      addr        <= addr + 3'd1;
      bus.termino <= ((int'(addr) + 1) >= song_len);
    end
    bus.nota_duracion <= mem[addr];
  end

  int checks = 0;
  int errors = 0;
  int n_emp, n_cue, n_act, n_fin;
  int emp_at, emp_last, fin_at, act_first, tr_first;
  int cue_at [4];
  logic [63:0] act_mask;

  task automatic clear_stats();
    n_emp = 0; n_cue = 0; n_act = 0; n_fin = 0;
    emp_at = -1; emp_last = -1; fin_at = -1; act_first = -1; tr_first = -1;
    for (int i = 0; i < 4; i++) cue_at[i] = -1;
    act_mask = '0;
  endtask

  task automatic observe(input int r);
    if (bus.empiece) begin
      if (n_emp == 0) emp_at = r;
      emp_last = r;
      n_emp++;
    end
    if (bus.cuente) begin
      if (n_cue < 4) cue_at[n_cue] = r;
      n_cue++;
    end
    if (bus.nota_activa) begin
      if (n_act == 0) begin
        act_first = r;
        tr_first  = int'(bus.tiempo_restante);
      end
      if (r < 64) act_mask[r] = 1'b1;
      n_act++;
    end
    if (bus.cancion_fin) begin
      fin_at = r;
      n_fin++;
    end
  endtask

  task automatic play(input int n);
    clear_stats();
    @(negedge clock);
    bus.iniciar = 1'b1;
    for (int r = 1; r <= n; r++) begin
      @(negedge clock);
      bus.iniciar = 1'b0;
      observe(r);
    end
  endtask

  task automatic test_reset();
    logic [11:0] outs;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      bus.iniciar = 1'($urandom_range(0, 1));
      bus.detener = 1'($urandom_range(0, 1));
      bus.pausar  = 1'($urandom_range(0, 1));
      outs = {bus.empiece, bus.cuente, bus.nota_activa, bus.tiempo_restante, bus.cancion_fin};
      checks++;
      if (outs !== 12'h000) begin
        errors++;
        $display("FAIL reset_hold: outputs=%h required 000", outs);
      end
    end
    @(negedge clock);
    bus.iniciar = 1'b0; bus.detener = 1'b0; bus.pausar = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      outs = {bus.empiece, bus.cuente, bus.nota_activa, bus.tiempo_restante, bus.cancion_fin};
      checks++;
      if (outs !== 12'h000) begin
        errors++;
        $display("FAIL reset_release: outputs=%h required 000", outs);
      end
    end
  endtask

  task automatic test_single_note();
    mem[0] = 8'd3; song_len = 1;
    play(16);
    checks++; if (n_emp !== 1 || emp_at !== 1) begin errors++; $display("FAIL single_empiece: count=%0d at=%0d required 1 at 1", n_emp, emp_at); end
    checks++; if (n_act !== 6 || act_first !== 4) begin errors++; $display("FAIL single_activa: count=%0d first=%0d required 6 first 4", n_act, act_first); end
    checks++; if (tr_first !== 3) begin errors++; $display("FAIL single_tiempo: got %0d required 3", tr_first); end
    checks++; if (n_cue !== 1 || cue_at[0] !== 10) begin errors++; $display("FAIL single_cuente: count=%0d at=%0d required 1 at 10", n_cue, cue_at[0]); end
    checks++; if (n_fin !== 1 || fin_at !== 12) begin errors++; $display("FAIL single_fin: count=%0d at=%0d required 1 at 12", n_fin, fin_at); end
    checks++; if (bus.tiempo_restante !== 8'd0 || bus.nota_activa !== 1'b0) begin errors++; $display("FAIL single_idle: tiempo=%0d activa=%b required 0 0", bus.tiempo_restante, bus.nota_activa); end
  endtask

  task automatic test_zero_note();
    mem[0] = 8'd2; mem[1] = 8'd0; mem[2] = 8'd1; song_len = 3;
    play(24);
    checks++; if (n_cue !== 3) begin errors++; $display("FAIL zero_cuente_count: got %0d required 3", n_cue); end
    checks++; if (cue_at[0] !== 8 || cue_at[1] !== 12 || cue_at[2] !== 18) begin errors++; $display("FAIL zero_spacing: at %0d %0d %0d required 8 12 18", cue_at[0], cue_at[1], cue_at[2]); end
    checks++; if (n_act !== 6 || act_mask[15:9] !== 7'd0) begin errors++; $display("FAIL zero_activa: count=%0d mask=%h required 6 and none in 9..15", n_act, act_mask); end
    checks++; if (n_fin !== 1 || fin_at !== 20) begin errors++; $display("FAIL zero_fin: count=%0d at=%0d required 1 at 20", n_fin, fin_at); end
  endtask

  task automatic test_pause();
    int t6, t10, t13;
    t6 = -1; t10 = -1; t13 = -1;
    mem[0] = 8'd4; song_len = 1;
    clear_stats();
    @(negedge clock);
    bus.iniciar = 1'b1;
    for (int r = 1; r <= 22; r++) begin
      @(negedge clock);
      bus.iniciar = 1'b0;
      bus.pausar  = (r >= 6 && r <= 10);
      observe(r);
      if (r == 6)  t6  = int'(bus.tiempo_restante);
      if (r == 10) t10 = int'(bus.tiempo_restante);
      if (r == 13) t13 = int'(bus.tiempo_restante);
    end
    bus.pausar = 1'b0;
    checks++; if (n_act !== 13) begin errors++; $display("FAIL pause_activa: got %0d required 13", n_act); end
    checks++; if (t6 !== 3 || t10 !== 3) begin errors++; $display("FAIL pause_frozen: t6=%0d t10=%0d required 3 3", t6, t10); end
    checks++; if (t13 !== 2) begin errors++; $display("FAIL pause_resume: got %0d required 2", t13); end
    checks++; if (n_cue !== 1 || cue_at[0] !== 17) begin errors++; $display("FAIL pause_cuente: count=%0d at=%0d required 1 at 17", n_cue, cue_at[0]); end
  endtask

  task automatic test_restart();
    int t6, t10;
    t6 = -1; t10 = -1;
    mem[0] = 8'd6; song_len = 1;
    clear_stats();
    @(negedge clock);
    bus.iniciar = 1'b1;
    for (int r = 1; r <= 20; r++) begin
      @(negedge clock);
      bus.iniciar = (r == 6);
      if (r == 6) begin
        t6 = int'(bus.tiempo_restante);
        mem[0] = 8'd2;
      end
      observe(r);
      if (r == 10) t10 = int'(bus.tiempo_restante);
    end
    checks++; if (t6 !== 5) begin errors++; $display("FAIL restart_pre: tiempo=%0d required 5", t6); end
    checks++; if (n_emp !== 2 || emp_last !== 7) begin errors++; $display("FAIL restart_empiece: count=%0d last=%0d required 2 at 7", n_emp, emp_last); end
    checks++; if (n_cue !== 1 || cue_at[0] !== 14) begin errors++; $display("FAIL restart_cuente: count=%0d at=%0d required 1 at 14", n_cue, cue_at[0]); end
    checks++; if (t10 !== 2 || n_act !== 7 || act_mask[7] !== 1'b0) begin errors++; $display("FAIL restart_reload: tiempo=%0d activa=%0d required 2 and 7", t10, n_act); end
    checks++; if (n_fin !== 1 || fin_at !== 16) begin errors++; $display("FAIL restart_fin: count=%0d at=%0d required 1 at 16", n_fin, fin_at); end
  endtask

  task automatic test_abort();
    logic [11:0] o7, o10;
    o7 = 'x; o10 = 'x;
    mem[0] = 8'd5; song_len = 1;
    clear_stats();
    @(negedge clock);
    bus.iniciar = 1'b1;
    for (int r = 1; r <= 30; r++) begin
      @(negedge clock);
      bus.iniciar = (r == 8);
      bus.detener = (r >= 6 && r <= 9);
      observe(r);
      if (r == 7)  o7  = {bus.empiece, bus.cuente, bus.nota_activa, bus.tiempo_restante, bus.cancion_fin};
      if (r == 10) o10 = {bus.empiece, bus.cuente, bus.nota_activa, bus.tiempo_restante, bus.cancion_fin};
    end
    bus.detener = 1'b0;
    checks++; if (o7 !== 12'h000) begin errors++; $display("FAIL abort_outputs: outputs=%h required 000", o7); end
    checks++; if (o10 !== 12'h000) begin errors++; $display("FAIL abort_priority: outputs=%h required 000", o10); end
    checks++; if (n_emp !== 1 || n_cue !== 0 || n_fin !== 0 || n_act !== 3) begin errors++; $display("FAIL abort_pulses: emp=%0d cue=%0d fin=%0d act=%0d required 1 0 0 3", n_emp, n_cue, n_fin, n_act); end
  endtask

  task automatic test_reset_mid_song();
    logic [11:0] outs;
    mem[0] = 8'd5; song_len = 1;
    play(6);
    #2 reset = 1'b0;
    #1 outs = {bus.empiece, bus.cuente, bus.nota_activa, bus.tiempo_restante, bus.cancion_fin};
    checks++; if (outs !== 12'h000) begin errors++; $display("FAIL reset_async: outputs=%h required 000", outs); end
    @(negedge clock);
    reset = 1'b1;
    clear_stats();
    for (int r = 1; r <= 20; r++) begin
      @(negedge clock);
      observe(r);
    end
    checks++; if (n_emp !== 0 || n_cue !== 0 || n_fin !== 0 || n_act !== 0) begin errors++; $display("FAIL reset_mid_pulses: emp=%0d cue=%0d fin=%0d act=%0d required 0 0 0 0", n_emp, n_cue, n_fin, n_act); end
  endtask

  initial begin
    reset = 1'b0;
    bus.iniciar = 1'b0;
    bus.detener = 1'b0;
    bus.pausar  = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = 8'd0;
    test_reset();
    test_single_note();
    test_zero_note();
    test_pause();
    test_restart();
    test_abort();
    test_reset_mid_song();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
